// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common data bus (CDB) arbiter. Each of N execution units
//               owns a one-entry hold buffer for its {tag, data} result. A
//               round-robin arbiter picks one full buffer per cycle and
//               registers it onto the broadcast outputs, which fan out to
//               every reservation station and the ROB.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   N         number of requesters (>= 2); index 0 wins first after reset
//   TAG_W     tag width
//   DATA_W    data width
//   TAG_FREE  tag value meaning "no producer"; such results are swallowed
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-low (0 = reset)
//   flush      in   mispredict flush; drops every pending result
//   req_valid  in   [N]          requester i offers a result
//   req_tag    in   [N*TAG_W]    requester i at [i*TAG_W +: TAG_W]
//   req_data   in   [N*DATA_W]   requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  [N]          hold buffer i can take a result this cycle
//   enCDBwrt   out  broadcast valid (one cycle per broadcast)
//   CDBTag     out  broadcast tag (TAG_FREE when idle)
//   CDBData    out  broadcast data (holds last value when idle)
//   stall_cnt  out  [16] contention cycle counter, only with
//                   CDB_ARB_STATS_EN defined
// Build option
//   CDB_ARB_STATS_EN : adds stall_cnt, a saturating count of cycles in which
//                      more than one hold buffer was full.
// ============================================================================
module cdb_arbiter #(
  parameter int N        = 3,
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int TAG_FREE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [N-1:0]        req_valid,
  input  logic [N*TAG_W-1:0]  req_tag,
  input  logic [N*DATA_W-1:0] req_data,
  output logic [N-1:0]        req_ready,
  output logic                enCDBwrt,
  output logic [TAG_W-1:0]    CDBTag,
  output logic [DATA_W-1:0]   CDBData
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int                 c_PTR_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [TAG_W-1:0]   c_TAG_FREE = TAG_W'(TAG_FREE);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [N-1:0]        r_full;
  logic [TAG_W-1:0]    r_buf_tag  [N];
  logic [DATA_W-1:0]   r_buf_data [N];
  logic [c_PTR_W-1:0]  r_ptr;

  logic                r_cdb_en;
  logic [TAG_W-1:0]    r_cdb_tag;
  logic [DATA_W-1:0]   r_cdb_data;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [TAG_W-1:0]    w_in_tag  [N];
  logic [DATA_W-1:0]   w_in_data [N];
  logic [N-1:0]        w_tag_free;
  logic [N-1:0]        w_accept;
  logic [N-1:0]        w_grant;
  logic                w_gnt_any;
  logic [TAG_W-1:0]    w_sel_tag;
  logic [DATA_W-1:0]   w_sel_data;
  logic [c_PTR_W-1:0]  w_ptr_nxt;

  // Unpack the flattened request buses and qualify each handshake.
  // A TAG_FREE result still completes the handshake (ready is honoured) but
  // is not written, so it can never reach the bus.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign w_in_tag[gi]   = req_tag[gi*TAG_W +: TAG_W];
      assign w_in_data[gi]  = req_data[gi*DATA_W +: DATA_W];
      assign w_tag_free[gi] = (w_in_tag[gi] == c_TAG_FREE);
      assign w_accept[gi]   = req_valid[gi] & req_ready[gi] & ~w_tag_free[gi];
    end
  endgenerate

  // A buffer being drained this cycle frees up at the same edge, so it can
  // take a new result back-to-back. Ready depends only on registered state.
  assign req_ready = ~r_full | w_grant;

  // --------------------------------------------------------------------------
  // Round-robin grant: first full buffer at or after r_ptr, wrapping at N.
  // Built purely from registered state so the grant is glitch-free and has
  // no path from the request inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    int j;
    w_grant   = '0;
    w_gnt_any = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      for (int i = 0; i < N; i++) begin
        if (!w_gnt_any && (j == i) && r_full[i]) begin
          w_grant[i] = 1'b1;
          w_gnt_any  = 1'b1;
        end
      end
    end
  end

  // One-hot AND-OR mux of the granted entry, plus the pointer that follows
  // the winner so it drops to lowest priority on the next round.
  always_comb begin
    w_sel_tag  = '0;
    w_sel_data = '0;
    w_ptr_nxt  = r_ptr;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_sel_tag  = w_sel_tag  | r_buf_tag[i];
        w_sel_data = w_sel_data | r_buf_data[i];
        w_ptr_nxt  = (i == N - 1) ? '0 : c_PTR_W'(i + 1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Hold buffers. Accept takes precedence over the drain so that a
  // same-edge grant and accept on one index broadcasts the old entry and
  // keeps the new one. Payload registers need no reset: r_full gates them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        r_full[i] <= 1'b0;
      end else if (flush) begin
        r_full[i] <= 1'b0;
      end else if (w_accept[i]) begin
        r_full[i]     <= 1'b1;
        r_buf_tag[i]  <= w_in_tag[i];
        r_buf_data[i] <= w_in_data[i];
      end else if (w_grant[i]) begin
        r_full[i] <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Broadcast registers and round-robin pointer. A flush suppresses the
  // pending grant but leaves the pointer alone; whatever was already on the
  // bus during the flush cycle has been seen by the consumers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_cdb_en   <= 1'b0;
      r_cdb_tag  <= c_TAG_FREE;
      r_cdb_data <= '0;
    end else if (flush) begin
      r_cdb_en   <= 1'b0;
      r_cdb_tag  <= c_TAG_FREE;
    end else if (w_gnt_any) begin
      r_cdb_en   <= 1'b1;
      r_cdb_tag  <= w_sel_tag;
      r_cdb_data <= w_sel_data;
      r_ptr      <= w_ptr_nxt;
    end else begin
      r_cdb_en   <= 1'b0;
      r_cdb_tag  <= c_TAG_FREE;
    end
  end

  assign enCDBwrt = r_cdb_en;
  assign CDBTag   = r_cdb_tag;
  assign CDBData  = r_cdb_data;

`ifdef CDB_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Contention counter: a cycle counts when two or more buffers are full,
  // i.e. at least one result is waiting behind another. Survives flushes.
  // --------------------------------------------------------------------------
  logic [15:0] r_stall_cnt;
  logic        w_contend;

  assign w_contend = ($countones(r_full) > 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_contend && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Self-checking bench for cdb_arbiter. Expected broadcasts are
//               queued when the stimulus is driven and retired in order by a
//               bus monitor; directed checks cover reset, latency, round-robin
//               order, back-pressure, flush and TAG_FREE handling.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N        = 3;
  localparam int TAG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int TAG_FREE = 0;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [N-1:0]        req_valid;
  logic [N*TAG_W-1:0]  req_tag;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic                enCDBwrt;
  logic [TAG_W-1:0]    CDBTag;
  logic [DATA_W-1:0]   CDBData;
`ifdef CDB_ARB_STATS_EN
  logic [15:0]         stall_cnt;
`endif

  int n_vec     = 0;
  int n_miscmp  = 0;

  logic [TAG_W+DATA_W-1:0] exp_q [$];
  logic [TAG_W+DATA_W-1:0] mon_e;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .N        (N),
    .TAG_W    (TAG_W),
    .DATA_W   (DATA_W),
    .TAG_FREE (TAG_FREE)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .enCDBwrt  (enCDBwrt),
    .CDBTag    (CDBTag),
    .CDBData   (CDBData)
`ifdef CDB_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d);
    req_valid[i]                 = v;
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
  endtask

  task automatic exp_push(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    exp_q.push_back({t, d});
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    flush = 1'b0;
    clr_req();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Bus monitor: every broadcast must match the oldest queued expectation.
  always @(negedge clk) begin
    if (enCDBwrt === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("bcast_unexpected", 64'(enCDBwrt), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("bcast_tag",  64'(CDBTag),  64'(mon_e[TAG_W+DATA_W-1:DATA_W]));
        check_eq("bcast_data", 64'(CDBData), 64'(mon_e[DATA_W-1:0]));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    clr_req();

    // ---------------- reset and idle ----------------
    repeat (2) @(negedge clk);
    check_eq("rst_en",    64'(enCDBwrt),  64'd0);
    check_eq("rst_tag",   64'(CDBTag),    64'(TAG_FREE));
    check_eq("rst_data",  64'(CDBData),   64'd0);
    check_eq("rst_ready", 64'(req_ready), 64'b111);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_en",    64'(enCDBwrt),  64'd0);
    check_eq("idle_ready", 64'(req_ready), 64'b111);

    // ---------------- single request, best-case latency ----------------
    set_req(1, 1'b1, 5'd5, 32'hDEAD);
    exp_push(5'd5, 32'hDEAD);
    @(negedge clk);                               // accepted at edge k
    clr_req();
    check_eq("single_not_yet", 64'(enCDBwrt),  64'd0);
    check_eq("single_ready",   64'(req_ready), 64'b111);
    @(negedge clk);                               // broadcast after edge k+1
    check_eq("single_en",      64'(enCDBwrt),  64'd1);
    @(negedge clk);
    check_eq("single_en_drop", 64'(enCDBwrt),  64'd0);
    check_eq("single_tag_idle", 64'(CDBTag),   64'(TAG_FREE));
    check_eq("single_data_hold", 64'(CDBData), 64'h0000DEAD);
    check_eq("single_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- all three requesting every cycle ----------------
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, TAG_W'(i + 1), 32'hA000_0000 + 32'(i + 1));
    end
    for (int b = 0; b < 8; b++) begin
      exp_push(TAG_W'((b % 3) + 1), 32'hA000_0000 + 32'((b % 3) + 1));
    end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check_eq("rr_b2b_en", 64'(enCDBwrt), 64'd1);
      end
      if (c == 6) begin
        clr_req();
      end
    end
    @(negedge clk);
    check_eq("rr_idle_en", 64'(enCDBwrt), 64'd0);
    check_eq("rr_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- back-pressure on requester 2 ----------------
    do_reset();
    set_req(0, 1'b1, 5'd4, 32'hB004);
    set_req(1, 1'b1, 5'd6, 32'hB006);
    set_req(2, 1'b1, 5'd9, 32'hB009);
    exp_push(5'd4, 32'hB004);
    exp_push(5'd6, 32'hB006);
    exp_push(5'd9, 32'hB009);
    @(negedge clk);                               // e1: all three buffered
    clr_req();
    set_req(2, 1'b1, 5'd7, 32'hB007);             // held until ready
    exp_push(5'd7, 32'hB007);
    check_eq("bp_ready2_e1", 64'(req_ready[2]), 64'd0);
    @(negedge clk);                               // e2: grant 0
    check_eq("bp_ready2_e2", 64'(req_ready[2]), 64'd0);
    @(negedge clk);                               // e3: grant 1, 2 granted next
    check_eq("bp_ready2_gnt", 64'(req_ready[2]), 64'd1);
    @(negedge clk);                               // e4: tag 7 accepted
    clr_req();
    @(negedge clk);                               // e5: tag 7 broadcast
    check_eq("bp_bcast7_en", 64'(enCDBwrt), 64'd1);
    @(negedge clk);
    check_eq("bp_idle_en", 64'(enCDBwrt), 64'd0);
    check_eq("bp_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- flush ----------------
    do_reset();
    set_req(0, 1'b1, 5'd10, 32'hC010);
    set_req(2, 1'b1, 5'd12, 32'hC012);
    exp_push(5'd10, 32'hC010);                    // only tag 10 escapes
    @(negedge clk);                               // e1: buffers 0,2 full
    clr_req();
    @(negedge clk);                               // e2: tag 10 on bus, ptr=1
    check_eq("fl_prior_bcast", 64'(enCDBwrt), 64'd1);
    flush = 1'b1;
    set_req(1, 1'b1, 5'd11, 32'hC011);
    @(negedge clk);                               // e3: flush edge
    flush = 1'b0;
    clr_req();
    check_eq("fl_en_c1",  64'(enCDBwrt),  64'd0);
    check_eq("fl_tag_c1", 64'(CDBTag),    64'(TAG_FREE));
    check_eq("fl_ready",  64'(req_ready), 64'b111);
    @(negedge clk);
    check_eq("fl_en_c2",  64'(enCDBwrt),  64'd0);
    // Pointer kept at 1: requester 1 must win over requester 0.
    set_req(0, 1'b1, 5'd14, 32'hC014);
    set_req(1, 1'b1, 5'd13, 32'hC013);
    exp_push(5'd13, 32'hC013);
    exp_push(5'd14, 32'hC014);
    @(negedge clk);
    clr_req();
    @(negedge clk);
    check_eq("fl_post_en1", 64'(enCDBwrt), 64'd1);
    @(negedge clk);
    check_eq("fl_post_en2", 64'(enCDBwrt), 64'd1);
    @(negedge clk);
    check_eq("fl_idle_en", 64'(enCDBwrt), 64'd0);
    check_eq("fl_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- TAG_FREE request is swallowed ----------------
    set_req(0, 1'b1, TAG_W'(TAG_FREE), 32'h1234_5678);
    check_eq("tf_ready", 64'(req_ready[0]), 64'd1);
    @(negedge clk);
    clr_req();
    check_eq("tf_not_held", 64'(req_ready), 64'b111);
    @(negedge clk);
    check_eq("tf_en_c1", 64'(enCDBwrt), 64'd0);
    @(negedge clk);
    check_eq("tf_en_c2", 64'(enCDBwrt), 64'd0);

    // ---------------- two-way contention for four cycles ----------------
    do_reset();
`ifdef CDB_ARB_STATS_EN
    check_eq("stall_rst", 64'(stall_cnt), 64'd0);
`endif
    set_req(0, 1'b1, 5'd20, 32'hD020);
    set_req(1, 1'b1, 5'd21, 32'hD021);
    for (int b = 0; b < 5; b++) begin
      exp_push((b % 2 == 0) ? 5'd20 : 5'd21, (b % 2 == 0) ? 32'hD020 : 32'hD021);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check_eq("ct_b2b_en", 64'(enCDBwrt), 64'd1);
      end
      if (c == 4) begin
        clr_req();
      end
    end
    @(negedge clk);
    check_eq("ct_idle_en", 64'(enCDBwrt), 64'd0);
`ifdef CDB_ARB_STATS_EN
    check_eq("stall_cnt4", 64'(stall_cnt), 64'd4);
`endif
    check_eq("final_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
